uart_hex_parser: RTL and testbench

Receive-side counterpart to the hex logger. It consumes the byte stream from the UART receiver, parses line-terminated ASCII hex numbers, and presents each value on a valid/ready output. Debug values and commands typed on the host terminal therefore reach fabric logic directly. It sits between the UART RX byte stream (upstream) and any register or command consumer (downstream), all in the pll_clk domain.

---
 rtl/uart_hex_parser.sv | 146 ++++++++++++++
 tb/tb_uart_hex_parser.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_hex_parser.sv
// Parses CR/LF-terminated ASCII hex lines from a UART RX byte stream and
// presents each value on a valid/ready output, flagging malformed lines.
module uart_hex_parser #(
  parameter int unsigned MAX_DIGITS = 4,
  localparam int unsigned VW = 4 * MAX_DIGITS
) (
  input  logic          pll_clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  output logic          out_valid,
  output logic [VW-1:0] out_value,
  input  logic          out_ready,
  output logic          err,
  output logic [1:0]    err_code
);

  localparam int unsigned CW = $clog2(MAX_DIGITS + 1);

  localparam logic [1:0] CODE_BAD_CHAR   = 2'b01;
  localparam logic [1:0] CODE_TOO_LONG   = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    HOLD,
    DISCARD
  } state_t;

  state_t        state, state_next;
  logic [VW-1:0] acc, acc_next;
  logic [CW-1:0] cnt, cnt_next;
  logic [VW-1:0] value_next;
  logic          err_next;
  logic [1:0]    code_next;

  logic          is_digit;
  logic          is_term;
  logic [3:0]    nibble;
  logic          take;

  // Character classification of the byte currently on in_data.
  always_comb begin
    is_digit = 1'b0;
    nibble   = '0;
    if (in_data >= 8'h30 && in_data <= 8'h39) begin
      is_digit = 1'b1;
      nibble   = in_data[3:0];
    end else if ((in_data >= 8'h41 && in_data <= 8'h46) ||
                 (in_data >= 8'h61 && in_data <= 8'h66)) begin
      is_digit = 1'b1;
      nibble   = in_data[3:0] + 4'd9;
    end
    is_term = (in_data == 8'h0D) || (in_data == 8'h0A);
  end

  assign in_ready  = (state != HOLD);
  assign out_valid = (state == HOLD);
  assign take      = in_valid && in_ready;

  always_comb begin
    state_next = state;
    acc_next   = acc;
    cnt_next   = cnt;
    value_next = out_value;
    err_next   = 1'b0;
    code_next  = err_code;

    unique case (state)
      IDLE: begin
        if (take) begin
          if (is_digit) begin
            acc_next   = VW'(nibble);
            cnt_next   = CW'(1);
            state_next = ACCUM;
          end else if (!is_term) begin
            err_next   = 1'b1;
            code_next  = CODE_BAD_CHAR;
            state_next = DISCARD;
          end
        end
      end

      ACCUM: begin
        if (take) begin
          if (is_digit) begin
            if (cnt == CW'(MAX_DIGITS)) begin
              err_next   = 1'b1;
              code_next  = CODE_TOO_LONG;
              state_next = DISCARD;
            end else begin
              acc_next = (acc << 4) | VW'(nibble);
              cnt_next = cnt + CW'(1);
            end
          end else if (is_term) begin
            value_next = acc;
            state_next = HOLD;
          end else begin
            err_next   = 1'b1;
            code_next  = CODE_BAD_CHAR;
            state_next = DISCARD;
          end
        end
      end

      HOLD: begin
        if (out_ready) begin
          acc_next   = '0;
          cnt_next   = '0;
          state_next = IDLE;
        end
      end

      DISCARD: begin
        // Rest of a rejected line is swallowed silently up to its terminator.
        if (take && is_term) begin
          acc_next   = '0;
          cnt_next   = '0;
          state_next = IDLE;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge pll_clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      out_value <= '0;
      err       <= 1'b0;
      err_code  <= '0;
    end else begin
      state     <= state_next;
      acc       <= acc_next;
      cnt       <= cnt_next;
      out_value <= value_next;
      err       <= err_next;
      err_code  <= code_next;
    end
  end

endmodule

// File: tb/tb_uart_hex_parser.sv
// Directed bench for uart_hex_parser: a line-level reference model checked
// every cycle, plus literal expectations for each directed scenario.
module tb_uart_hex_parser;

  logic        pll_clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        out_valid;
  logic [15:0] out_value;
  logic        out_ready;
  logic        err;
  logic [1:0]  err_code;

  int unsigned passed = 0;
  int unsigned total  = 0;

  uart_hex_parser #(.MAX_DIGITS(4)) dut (
    .pll_clk  (pll_clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_value(out_value),
    .out_ready(out_ready),
    .err      (err),
    .err_code (err_code)
  );

  always #5 pll_clk = ~pll_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    else passed++;
  endtask

  function automatic int hexval(input logic [7:0] c);
    string      digs = "0123456789ABCDEF";
    logic [7:0] u;
    u = (c >= 8'h61 && c <= 8'h7A) ? c - 8'd32 : c;
    for (int k = 0; k < 16; k++) if (digs[k] == u) return k;
    return -1;
  endfunction

  // Line-level reference model: digits typed so far, whether the line is
  // being thrown away, and the value waiting for the consumer.
  bit          started = 0;
  bit          m_valid, m_disc, m_err;
  int          m_ndig;
  logic [15:0] m_acc, m_value;
  logic [1:0]  m_code;

  always @(posedge pll_clk) begin
    int h;
    bit term;
    m_err = 0;
    if (!rst_n) begin
      started = 1;
      m_valid = 0; m_disc = 0; m_ndig = 0; m_acc = 0; m_value = 0; m_code = 0;
    end else if (m_valid) begin
      if (out_ready) m_valid = 0;
    end else if (in_valid) begin
      h    = hexval(in_data);
      term = (in_data == 8'h0D) || (in_data == 8'h0A);
      if (m_disc) begin
        if (term) m_disc = 0;
      end else if (term) begin
        if (m_ndig > 0) begin m_valid = 1; m_value = m_acc; end
        m_ndig = 0; m_acc = 0;
      end else if (h >= 0 && m_ndig < 4) begin
        m_acc = m_acc * 16 + 16'(h);
        m_ndig++;
      end else begin
        m_err = 1; m_code = (h >= 0) ? 2'd2 : 2'd1;
        m_disc = 1; m_ndig = 0; m_acc = 0;
      end
    end
  end

  logic [15:0] outs[$];
  logic [1:0]  errs[$];

  always @(negedge pll_clk) begin
    if (started) begin
      chk("in_ready",  in_ready,  !m_valid);
      chk("out_valid", out_valid, m_valid);
      chk("out_value", out_value, m_value);
      chk("err",       err,       m_err);
      chk("err_code",  err_code,  m_code);
      if (out_valid && out_ready) outs.push_back(out_value);
      if (err) errs.push_back(err_code);
    end
  end

  int last_wait;

  task automatic send(input string s);
    for (int i = 0; i < s.len(); i++) begin
      bit done = 0;
      int n = 0;
      in_valid = 1;
      in_data  = s[i];
      while (!done && n < 200) begin
        @(negedge pll_clk);
        done = in_ready;
        @(posedge pll_clk);
        #1;
        n++;
      end
      if (!done) chk("accept_timeout", 0, 1);
      last_wait = n;
    end
    in_valid = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge pll_clk); #1; end
  endtask

  task automatic clear_logs();
    outs.delete();
    errs.delete();
  endtask

  initial begin
    rst_n = 0; in_valid = 0; in_data = 8'h00; out_ready = 1;
    idle(2);
    rst_n = 1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);

    clear_logs(); send("1A3F\r"); idle(3);
    chk("t1_count", outs.size(), 1);
    if (outs.size() > 0) chk("t1_value", outs[0], 16'h1A3F);
    chk("t1_errs", errs.size(), 0);

    clear_logs(); send("7\r\n"); send("ab\n"); idle(3);
    chk("t2_count", outs.size(), 2);
    if (outs.size() > 1) begin
      chk("t2_value0", outs[0], 16'h0007);
      chk("t2_value1", outs[1], 16'h00AB);
    end

    clear_logs(); send("12G4\r55\r"); idle(3);
    chk("t3_errs", errs.size(), 1);
    if (errs.size() > 0) chk("t3_code", errs[0], 2'b01);
    chk("t3_count", outs.size(), 1);
    if (outs.size() > 0) chk("t3_value", outs[0], 16'h0055);

    clear_logs(); send("12345\r"); send("0\r"); idle(3);
    chk("t4_errs", errs.size(), 1);
    if (errs.size() > 0) chk("t4_code", errs[0], 2'b10);
    chk("t4_count", outs.size(), 1);
    if (outs.size() > 0) chk("t4_value", outs[0], 16'h0000);

    clear_logs(); out_ready = 0; send("AB\r");
    in_valid = 1; in_data = "9";
    for (int i = 0; i < 10; i++) begin
      @(negedge pll_clk);
      chk("t5_hold_ready", in_ready, 0);
      chk("t5_hold_value", out_value, 16'h00AB);
      @(posedge pll_clk); #1;
    end
    out_ready = 1;
    send("9");
    chk("t5_accept_delay", last_wait, 2);
    send("\r"); idle(3);
    chk("t5_count", outs.size(), 2);
    if (outs.size() > 1) begin
      chk("t5_value0", outs[0], 16'h00AB);
      chk("t5_value1", outs[1], 16'h0009);
    end

    clear_logs(); send("AB");
    rst_n = 0; idle(1);
    chk("t6_rst_valid", out_valid, 0);
    chk("t6_rst_ready", in_ready, 1);
    chk("t6_rst_value", out_value, 16'h0000);
    chk("t6_rst_code", err_code, 2'b00);
    chk("t6_rst_err", err, 0);
    rst_n = 1;
    send("C\r"); idle(3);
    chk("t6_count", outs.size(), 1);
    if (outs.size() > 0) chk("t6_value", outs[0], 16'h000C);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    chk("global_timeout", 0, 1);
    $display("%0d/%0d checks passed", passed, total);
    $fatal(1, "FAIL global timeout");
  end

endmodule
